// File: rtl/screen_flow_ctrl.sv
// screen_flow_ctrl: attract/intro/play/game-over screen sequencer with credit counter
// ports: clk, resetN (async active-low); startOfFrame frame pulse; coinKey/startKey debounced key levels;
//        gameOver game-lost level; standBy blink phase; startScreenEn/gameEn/gameOverEn screen enables;
//        newGame one-cycle pulse entering play; credits current credit count
module screen_flow_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter int INTRO_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int MAX_CREDITS  = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       coinKey,
  input  logic       startKey,
  input  logic       gameOver,
  output logic       standBy,
  output logic       startScreenEn,
  output logic       gameEn,
  output logic       gameOverEn,
  output logic       newGame,
  output logic [3:0] credits
);
  typedef enum logic [1:0] {ATTRACT, INTRO, PLAY, OVER} state_e;
  state_e     state_q, state_d;
  logic [3:0] credits_q, credits_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       stand_by_q, stand_by_d;
  logic       new_game_q, new_game_d;
  logic       coin_q, coin_dly_q, start_q, start_dly_q;
  logic       coin_rise, start_rise, start_ok;
  // keys are sampled first, so an event acts one edge after the key is first seen high
  assign coin_rise  = coin_q & ~coin_dly_q;
  assign start_rise = start_q & ~start_dly_q;
  // start is judged against the credit count before this cycle's coin
  assign start_ok   = start_rise && state_q == ATTRACT && credits_q != 4'd0;
  assign credits_d  = credits_q + 4'(coin_rise && credits_q < 4'(MAX_CREDITS)) - 4'(start_ok);
  always_comb begin
    state_d     = state_q;
    stand_by_d  = stand_by_q;
    new_game_d  = 1'b0;
    frame_cnt_d = startOfFrame ? frame_cnt_q + 8'd1 : frame_cnt_q;
    unique case (state_q)
      ATTRACT:
        if (start_ok) begin
          state_d    = INTRO;
          stand_by_d = 1'b0;
        end else if (startOfFrame && frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
          stand_by_d  = ~stand_by_q;
          frame_cnt_d = 8'd0;
        end
      INTRO:
        if (startOfFrame && frame_cnt_q == 8'(INTRO_FRAMES - 1)) begin
          state_d    = PLAY;
          new_game_d = 1'b1;
        end
      PLAY:
        if (gameOver) state_d = OVER;
      OVER:
        if (startOfFrame && frame_cnt_q == 8'(OVER_FRAMES - 1)) begin
          state_d    = ATTRACT;
          stand_by_d = 1'b0;
        end
    endcase
    if (state_d != state_q) frame_cnt_d = 8'd0;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ATTRACT;
      credits_q   <= 4'd0;
      frame_cnt_q <= 8'd0;
      stand_by_q  <= 1'b0;
      new_game_q  <= 1'b0;
      coin_q      <= 1'b0;
      coin_dly_q  <= 1'b0;
      start_q     <= 1'b0;
      start_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      frame_cnt_q <= frame_cnt_d;
      stand_by_q  <= stand_by_d;
      new_game_q  <= new_game_d;
      coin_q      <= coinKey;
      coin_dly_q  <= coin_q;
      start_q     <= startKey;
      start_dly_q <= start_q;
    end
  end
  assign standBy       = stand_by_q & (state_q == ATTRACT);
  assign startScreenEn = state_q == ATTRACT;
  assign gameEn        = state_q == INTRO || state_q == PLAY;
  assign gameOverEn    = state_q == OVER;
  assign newGame       = new_game_q;
  assign credits       = credits_q;
endmodule
